// File: rtl/axis_multi_splitter_pkg.sv
// Shared types and helpers for axis_multi_splitter: segment index, control state,
// and the zero-length-skipping segment search.
package axis_multi_splitter_pkg;

    localparam int SPLIT_OUTPUTS    = 3;
    localparam int SPLIT_LEN_WIDTH  = 8;
    localparam int SPLIT_SEG_WIDTH  = $clog2(SPLIT_OUTPUTS);
    localparam int SPLIT_LENS_WIDTH = (SPLIT_OUTPUTS - 1) * SPLIT_LEN_WIDTH;

    typedef logic [SPLIT_SEG_WIDTH-1:0] seg_t;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam seg_t LAST_SEG = seg_t'(SPLIT_OUTPUTS - 1);

    // Lowest segment at or after cur with a nonzero length; the open-ended last port otherwise.
    function automatic seg_t next_nonzero_seg(
        input logic [SPLIT_LENS_WIDTH-1:0] lens,
        input seg_t                        cur
    );
        seg_t result;
        logic found;
        result = LAST_SEG;
        found  = 1'b0;
        for (int k = 0; k < SPLIT_OUTPUTS - 1; k++) begin
            if (!found && k >= int'(cur) &&
                lens[k*SPLIT_LEN_WIDTH +: SPLIT_LEN_WIDTH] != '0) begin
                result = seg_t'(k);
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_multi_splitter_if.sv
// AXI-Stream bundle with LANES parallel channels sharing one parameter set;
// LANES=1 for a single stream, LANES=N for a demuxed port group.
interface axis_multi_splitter_if #(
    parameter int DATA_BYTES = 1,
    parameter int USER_BITS  = 1,
    parameter int LANES      = 1
);
    logic [LANES-1:0]              tvalid;
    logic [LANES-1:0]              tready;
    logic [LANES-1:0]              tlast;
    logic [LANES*DATA_BYTES*8-1:0] tdata;
    logic [LANES*USER_BITS-1:0]    tuser;

    modport master (output tvalid, tlast, tdata, tuser, input tready);
    modport slave  (input tvalid, tlast, tdata, tuser, output tready);
endinterface

// File: rtl/axis_register_slice.sv
// Generic pipeline register slice for a valid/ready stream: one cycle latency,
// full throughput, ready passes back combinationally from the downstream side.
module axis_register_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             sresetn,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [WIDTH-1:0] src_data,
    output logic             dst_valid,
    input  logic             dst_ready,
    output logic [WIDTH-1:0] dst_data
);
    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    assign src_ready = !valid_reg || dst_ready;
    assign dst_valid = valid_reg;
    assign dst_data  = data_reg;

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            valid_reg <= 1'b0;
        end else if (src_ready) begin
            valid_reg <= src_valid;
        end
    end

    // Payload needs no reset; it is only observed while valid_reg is set.
    always_ff @(posedge clk) begin
        if (src_valid && src_ready) begin
            data_reg <= src_data;
        end
    end

endmodule

// File: rtl/axis_multi_splitter.sv
// Splits each input packet into consecutive per-port segments with runtime lengths.
// Define AXIS_MULTI_SPLITTER_ERR_EN to add the err_short / err_count short-packet outputs.
module axis_multi_splitter
    import axis_multi_splitter_pkg::*;
#(
    parameter int AXIS_BYTES     = 1,
    parameter int AXIS_USER_BITS = 1,
    parameter int NUM_OUTPUTS    = axis_multi_splitter_pkg::SPLIT_OUTPUTS,
    parameter int LEN_WIDTH      = axis_multi_splitter_pkg::SPLIT_LEN_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 sresetn,
    axis_multi_splitter_if.slave                 axis_i,
    axis_multi_splitter_if.master                axis_o,
    input  logic [(NUM_OUTPUTS-1)*LEN_WIDTH-1:0] cfg_seg_len
`ifdef AXIS_MULTI_SPLITTER_ERR_EN
    ,
    output logic                                 err_short,
    output logic [15:0]                          err_count
`endif
);
    localparam int LW      = LEN_WIDTH;
    localparam int LENS_W  = (NUM_OUTPUTS - 1) * LEN_WIDTH;
    localparam int DW      = AXIS_BYTES * 8;
    localparam int UW      = AXIS_USER_BITS;
    localparam int SW      = $bits(seg_t);
    localparam int PW      = DW + UW + 1 + SW;

    logic              rdy_en_reg;
    state_t            state_reg, state_next;
    seg_t              seg_reg, seg_next;
    logic [LW-1:0]     cnt_reg, cnt_next;
    logic [LENS_W-1:0] lens_reg, lens_next;

    logic [LENS_W-1:0] lens_cur;
    seg_t              seg_cur;
    logic [LW-1:0]     len_arr [NUM_OUTPUTS];
    logic              seg_end, accept, in_last;

    logic              src_valid, src_ready, dst_valid, dst_ready;
    logic [PW-1:0]     src_data, dst_data;
    logic [DW-1:0]     held_data;
    logic [UW-1:0]     held_user;
    logic              held_last;
    seg_t              held_seg;

    genvar gi;

    // Between packets the live config drives the first beat; afterwards the latched copy.
    always_comb begin
        lens_cur = (state_reg == IDLE) ? cfg_seg_len : lens_reg;
        seg_cur  = (state_reg == IDLE) ? next_nonzero_seg(cfg_seg_len, '0) : seg_reg;
    end

    generate
        for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_len
            if (gi < NUM_OUTPUTS - 1) begin : g_sized
                assign len_arr[gi] = lens_cur[gi*LW +: LW];
            end else begin : g_open
                assign len_arr[gi] = '0;
            end
        end
    endgenerate

    assign in_last   = axis_i.tlast[0];
    assign src_valid = axis_i.tvalid[0] && rdy_en_reg && sresetn;
    assign accept    = src_valid && src_ready;
    assign seg_end   = (seg_cur != LAST_SEG) &&
                       (({1'b0, cnt_reg} + 1'b1) == {1'b0, len_arr[seg_cur]});

    assign axis_i.tready[0] = src_ready && rdy_en_reg && sresetn;

    always_comb begin
        state_next = state_reg;
        seg_next   = seg_reg;
        cnt_next   = cnt_reg;
        lens_next  = lens_reg;
        if (accept) begin
            if (state_reg == IDLE) begin
                lens_next = cfg_seg_len;
            end
            if (in_last) begin
                state_next = IDLE;
                seg_next   = next_nonzero_seg(lens_cur, '0);
                cnt_next   = '0;
            end else if (seg_end) begin
                state_next = BUSY;
                seg_next   = next_nonzero_seg(lens_cur, seg_t'(seg_cur + seg_t'(1)));
                cnt_next   = '0;
            end else begin
                state_next = BUSY;
                seg_next   = seg_cur;
                cnt_next   = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            rdy_en_reg <= 1'b0;
            state_reg  <= IDLE;
            seg_reg    <= '0;
            cnt_reg    <= '0;
            lens_reg   <= '0;
        end else begin
            rdy_en_reg <= 1'b1;
            state_reg  <= state_next;
            seg_reg    <= seg_next;
            cnt_reg    <= cnt_next;
            lens_reg   <= lens_next;
        end
    end

    assign src_data = {axis_i.tdata, axis_i.tuser, in_last || seg_end, seg_cur};

    axis_register_slice #(
        .WIDTH(PW)
    ) u_slice (
        .clk       (clk),
        .sresetn   (sresetn),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_data  (src_data),
        .dst_valid (dst_valid),
        .dst_ready (dst_ready),
        .dst_data  (dst_data)
    );

    assign {held_data, held_user, held_last, held_seg} = dst_data;
    assign dst_ready = axis_o.tready[held_seg];

    // One shared slice; the registered port index picks which valid bit is raised.
    generate
        for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_out
            assign axis_o.tvalid[gi]          = dst_valid && (held_seg == seg_t'(gi));
            assign axis_o.tlast[gi]           = held_last;
            assign axis_o.tdata[gi*DW +: DW]  = held_data;
            assign axis_o.tuser[gi*UW +: UW]  = held_user;
        end
    endgenerate

`ifdef AXIS_MULTI_SPLITTER_ERR_EN
    logic        err_short_reg;
    logic [15:0] err_count_reg;
    logic        short_hit;

    assign short_hit = accept && in_last && (seg_cur != LAST_SEG);

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            err_short_reg <= 1'b0;
            err_count_reg <= '0;
        end else begin
            err_short_reg <= short_hit;
            if (short_hit && err_count_reg != 16'hFFFF) begin
                err_count_reg <= err_count_reg + 16'd1;
            end
        end
    end

    assign err_short = err_short_reg;
    assign err_count = err_count_reg;
`endif

endmodule

// File: tb/tb_axis_multi_splitter.sv
// Scoreboard bench for axis_multi_splitter: a packet-level model queues expected
// beats in output order, and a negedge monitor pops and compares every handshake.
module tb_axis_multi_splitter;
    localparam int N  = 3;
    localparam int LW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                sresetn;
    logic [(N-1)*LW-1:0] cfg_seg_len;

    axis_multi_splitter_if #(.DATA_BYTES(1), .USER_BITS(1), .LANES(1)) axis_i ();
    axis_multi_splitter_if #(.DATA_BYTES(1), .USER_BITS(1), .LANES(N)) axis_o ();

`ifdef AXIS_MULTI_SPLITTER_ERR_EN
    logic        err_short;
    logic [15:0] err_count;
`endif

    axis_multi_splitter #(
        .AXIS_BYTES     (1),
        .AXIS_USER_BITS (1),
        .NUM_OUTPUTS    (N),
        .LEN_WIDTH      (LW)
    ) dut (
        .clk         (clk),
        .sresetn     (sresetn),
        .axis_i      (axis_i),
        .axis_o      (axis_o),
        .cfg_seg_len (cfg_seg_len)
`ifdef AXIS_MULTI_SPLITTER_ERR_EN
        ,
        .err_short   (err_short),
        .err_count   (err_count)
`endif
    );

    typedef struct packed {
        logic [1:0] port;
        logic [7:0] data;
        logic       user;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         exp_err = 0;
    int         err_pulses = 0;
    logic       rand_ready = 1'b0;
    logic [N-1:0] ready_fix = '1;

    logic [7:0] pkt_data [64];
    logic       pkt_user [64];
    int         pkt_len;

    logic       stall_pending = 1'b0;
    logic [1:0] stall_port;
    logic [7:0] stall_data;
    logic       stall_user;
    logic       stall_last;
    exp_t       e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Output-port ready driver: fixed pattern or 50% random per port per cycle.
    initial begin
        axis_o.tready = '1;
        forever begin
            @(posedge clk);
            #1;
            axis_o.tready = rand_ready ? N'($urandom) : ready_fix;
        end
    end

    task automatic make_packet(input int len, input logic [7:0] base);
        pkt_len = len;
        for (int i = 0; i < len; i++) begin
            pkt_data[i] = base + 8'(i);
            pkt_user[i] = 1'($urandom);
        end
    endtask

    // Reference: walk the ports in order, each takes min(len, remaining) words; the last takes the rest.
    task automatic model_packet(input int l0, input int l1);
        int pos;
        int take;
        int seg_len;
        int last_cnt;
        pos = 0;
        last_cnt = 0;
        for (int k = 0; k < N && pos < pkt_len; k++) begin
            seg_len = (k == 0) ? l0 : (k == 1) ? l1 : pkt_len;
            take = (seg_len < pkt_len - pos) ? seg_len : pkt_len - pos;
            for (int j = 0; j < take; j++) begin
                exp_q.push_back('{port: 2'(k), data: pkt_data[pos], user: pkt_user[pos],
                                  last: (j == take - 1)});
                pos++;
            end
            if (k == N - 1) last_cnt = take;
        end
        if (last_cnt == 0) exp_err++;
    endtask

    task automatic push_exp(input int port, input logic [7:0] d, input logic u, input logic l);
        exp_q.push_back('{port: 2'(port), data: d, user: u, last: l});
    endtask

    task automatic send_beat(input logic [7:0] d, input logic u, input logic l, output int waits);
        axis_i.tvalid = 1'b1;
        axis_i.tdata  = d;
        axis_i.tuser  = u;
        axis_i.tlast  = l;
        waits = 0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (axis_i.tready[0]) break;
            waits++;
        end
        if (waits >= 500) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout: got tready=0 for 500 cycles expected 1 (data %02h)", d);
        end
        @(posedge clk);
        #1;
        axis_i.tvalid = 1'b0;
    endtask

    task automatic send_packet(input int max_gap, input int change_at,
                               input logic [(N-1)*LW-1:0] new_cfg, output int stalls);
        int w;
        stalls = 0;
        for (int i = 0; i < pkt_len; i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
            send_beat(pkt_data[i], pkt_user[i], i == pkt_len - 1, w);
            stalls += w;
            if (i == change_at) cfg_seg_len = new_cfg;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!sresetn) begin
            stall_pending = 1'b0;
        end else begin
            if (axis_o.tvalid != '0) begin
                total++;
                if ($countones(axis_o.tvalid) > 1) begin
                    bad++;
                    $display("FAIL onehot_valid: got tvalid=%b expected at most one bit", axis_o.tvalid);
                end
            end
            if (stall_pending) begin
                total++;
                if (!axis_o.tvalid[stall_port] ||
                    axis_o.tdata[stall_port*8 +: 8] !== stall_data ||
                    axis_o.tuser[stall_port] !== stall_user ||
                    axis_o.tlast[stall_port] !== stall_last) begin
                    bad++;
                    $display("FAIL stall_stable: port %0d got v=%b d=%02h l=%b expected d=%02h l=%b",
                             stall_port, axis_o.tvalid, axis_o.tdata[stall_port*8 +: 8],
                             axis_o.tlast[stall_port], stall_data, stall_last);
                end
            end
            stall_pending = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (axis_o.tvalid[k]) begin
                    if (axis_o.tready[k]) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL unexpected_beat: got port %0d data %02h expected none",
                                     k, axis_o.tdata[k*8 +: 8]);
                        end else begin
                            e = exp_q.pop_front();
                            if (int'(e.port) != k || axis_o.tdata[k*8 +: 8] !== e.data ||
                                axis_o.tuser[k] !== e.user || axis_o.tlast[k] !== e.last) begin
                                bad++;
                                $display("FAIL beat: got port %0d d=%02h u=%b l=%b expected port %0d d=%02h u=%b l=%b",
                                         k, axis_o.tdata[k*8 +: 8], axis_o.tuser[k], axis_o.tlast[k],
                                         e.port, e.data, e.user, e.last);
                            end else begin
                                $display("beat port=%0d data=%02h user=%b last=%b", k, e.data, e.user, e.last);
                            end
                        end
                    end else begin
                        stall_pending = 1'b1;
                        stall_port    = 2'(k);
                        stall_data    = axis_o.tdata[k*8 +: 8];
                        stall_user    = axis_o.tuser[k];
                        stall_last    = axis_o.tlast[k];
                    end
                end
            end
`ifdef AXIS_MULTI_SPLITTER_ERR_EN
            if (err_short) err_pulses++;
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        sresetn       = 1'b0;
        cfg_seg_len   = '0;
        axis_i.tvalid = '0;
        axis_i.tdata  = '0;
        axis_i.tuser  = '0;
        axis_i.tlast  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tvalid", 32'(axis_o.tvalid), 0);
        check("reset_tready", 32'(axis_i.tready), 0);
`ifdef AXIS_MULTI_SPLITTER_ERR_EN
        check("reset_err", {err_short, err_count}, 0);
`endif
        sresetn = 1'b1;
        @(negedge clk);
        check("tready_cycle_after_reset", 32'(axis_i.tready), 0);
        @(posedge clk);
        #1;
        check("tready_up", 32'(axis_i.tready), 1);

        // len={2,3}, 8 beats, full throughput and one-cycle latency
        cfg_seg_len = {8'd3, 8'd2};
        make_packet(8, 8'h10);
        model_packet(2, 3);
        send_packet(0, -1, '0, stalls);
        check("throughput_stalls", stalls, 0);
        check("latency_last_beat", {axis_o.tvalid, axis_o.tlast[2], axis_o.tdata[23:16]},
              {3'b100, 1'b1, 8'h17});
        drain();

        // len={0,2}: port0 skipped
        cfg_seg_len = {8'd2, 8'd0};
        make_packet(4, 8'h20);
        model_packet(0, 2);
        send_packet(0, -1, '0, stalls);
        drain();

        // short packet then a full one
        cfg_seg_len = {8'd3, 8'd2};
        make_packet(3, 8'h30);
        model_packet(2, 3);
        send_packet(0, -1, '0, stalls);
        make_packet(6, 8'h40);
        model_packet(2, 3);
        send_packet(0, -1, '0, stalls);
        drain();
`ifdef AXIS_MULTI_SPLITTER_ERR_EN
        check("err_count_short", 32'(err_count), 1);
        check("err_pulses_short", err_pulses, 1);
`endif

        // config changed mid-packet only applies to the next packet
        cfg_seg_len = {8'd3, 8'd2};
        make_packet(7, 8'h50);
        model_packet(2, 3);
        send_packet(0, 2, {8'd1, 8'd1}, stalls);
        make_packet(4, 8'h58);
        model_packet(1, 1);
        send_packet(0, -1, '0, stalls);
        drain();

        // random ready and valid gaps
        rand_ready  = 1'b1;
        cfg_seg_len = {8'd4, 8'd1};
        for (int p = 0; p < 100; p++) begin
            make_packet($urandom_range(1, 10), 8'($urandom));
            model_packet(1, 4);
            send_packet(2, -1, '0, stalls);
        end
        rand_ready = 1'b0;
        drain();
`ifdef AXIS_MULTI_SPLITTER_ERR_EN
        check("err_count_random", 32'(err_count), exp_err);
        check("err_pulses_random", err_pulses, exp_err);
`endif

        // reset mid-packet with port1 stalled
        ready_fix = 3'b101;
        @(posedge clk);
        #1;
        cfg_seg_len = {8'd3, 8'd2};
        push_exp(0, 8'h60, 1'b0, 1'b0);
        push_exp(0, 8'h61, 1'b0, 1'b1);
        send_beat(8'h60, 1'b0, 1'b0, stalls);
        send_beat(8'h61, 1'b0, 1'b0, stalls);
        send_beat(8'h62, 1'b0, 1'b0, stalls);
        axis_i.tvalid = 1'b1;
        axis_i.tdata  = 8'h63;
        axis_i.tlast  = 1'b0;
        @(negedge clk);
        check("stalled_port1_valid", 32'(axis_o.tvalid), 32'(3'b010));
        check("stalled_tready", 32'(axis_i.tready), 0);
        @(posedge clk);
        #1;
        sresetn = 1'b0;
        @(posedge clk);
        #1;
        sresetn       = 1'b1;
        axis_i.tvalid = 1'b0;
        exp_err       = 0;
        err_pulses    = 0;
        ready_fix     = '1;
        check("midreset_tvalid", 32'(axis_o.tvalid), 0);
        check("midreset_tready", 32'(axis_i.tready), 0);
`ifdef AXIS_MULTI_SPLITTER_ERR_EN
        check("midreset_err_count", 32'(err_count), 0);
`endif
        @(posedge clk);
        #1;
        make_packet(4, 8'h70);
        model_packet(2, 3);
        send_packet(0, -1, '0, stalls);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
